vram_banked: RTL and testbench

- Parametrised successor to the two-byte SNES VRAM block. NUM_BANKS independent single-port block-RAM banks, each with its own toggle req/ack channel.
- Adds configurable read latency (1 or 2 cycles) and a hardware fill engine. The fill engine writes a constant to every address of every bank, used for PPU VRAM clear at boot or core reset.
- Sits between the PPU/DMA VRAM clients and on-chip BRAM.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_bank.sv | 92 +++++++++
 rtl/vram_banked.sv | 96 +++++++++
 tb/tb_vram_banked.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the banked VRAM: default geometry, fill FSM states
// and the read-latency legality check.
package vram_pkg;

    localparam int VRAM_NUM_BANKS = 2;
    localparam int VRAM_AW        = 15;
    localparam int VRAM_DW        = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/vram_bank.sv
// One VRAM byte bank: single-port BRAM with a toggle req/ack client port,
// optional second output stage, and a fill-engine write override.
module vram_bank
    import vram_pkg::*;
#(
    parameter int AW     = VRAM_AW,
    parameter int DW     = VRAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          req,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic          accept_en,
    input  logic          fill_we,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          ack,
    output logic [DW-1:0] dout
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic          pending;
    logic          in_flight;
    logic          accept;

    assign pending = req ^ ack;
    assign accept  = pending && accept_en && !in_flight;

    // Client accepts are blocked while filling, so the two writers never collide.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_addr] <= fill_data;
        end else if (accept && we) begin
            mem[addr] <= din;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic          s1_valid;
        logic          s1_rd;
        logic          s1_req;
        logic [DW-1:0] s1_data;

        assign in_flight = s1_valid;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_valid <= 1'b0;
                s1_rd    <= 1'b0;
                s1_req   <= 1'b0;
                s1_data  <= '0;
                ack      <= 1'b0;
                dout     <= '0;
            end else begin
                s1_valid <= accept;
                if (accept) begin
                    s1_rd  <= !we;
                    s1_req <= req;
                    if (!we) begin
                        s1_data <= mem[addr];
                    end
                end
                if (s1_valid) begin
                    ack <= s1_req;
                    if (s1_rd) begin
                        dout <= s1_data;
                    end
                end
            end
        end
    end else begin : g_lat1
        assign in_flight = 1'b0;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ack  <= 1'b0;
                dout <= '0;
            end else if (accept) begin
                ack <= req;
                if (!we) begin
                    dout <= mem[addr];
                end
            end
        end
    end

endmodule

// File: rtl/vram_banked.sv
// Banked VRAM top: NUM_BANKS independent byte banks plus a fill engine that
// writes one constant to every address of every bank.
//   state   | meaning
//   ST_IDLE | client requests accepted, waiting for fill_start
//   ST_FILL | writing fill value at fill_cnt in all banks, clients held off
module vram_banked
    import vram_pkg::*;
#(
    parameter int NUM_BANKS = VRAM_NUM_BANKS,
    parameter int AW        = VRAM_AW,
    parameter int DW        = VRAM_DW,
    parameter int RD_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BANKS*AW-1:0] bank_addr,
    input  logic [NUM_BANKS-1:0]    bank_req,
    output logic [NUM_BANKS-1:0]    bank_ack,
    input  logic [NUM_BANKS-1:0]    bank_we,
    input  logic [NUM_BANKS*DW-1:0] bank_din,
    output logic [NUM_BANKS*DW-1:0] bank_dout,
    input  logic                    fill_start,
    input  logic [DW-1:0]           fill_value,
    output logic                    fill_busy,
    output logic                    fill_done
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("vram_banked: RD_LAT must be 1 or 2");
    end

    fill_state_t   state;
    logic [AW-1:0] fill_cnt;
    logic [DW-1:0] fill_val;
    logic          fill_we;
    logic          accept_en;

    assign fill_we   = (state == ST_FILL);
    // A fill_start arriving with a pending request wins the cycle.
    assign accept_en = (state == ST_IDLE) && !fill_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            fill_val  <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state     <= ST_FILL;
                        fill_cnt  <= '0;
                        fill_val  <= fill_value;
                        fill_busy <= 1'b1;
                    end
                end
                ST_FILL: begin
                    fill_cnt <= fill_cnt + AW'(1);
                    if (fill_cnt == LAST_ADDR) begin
                        state     <= ST_IDLE;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        vram_bank #(
            .AW     (AW),
            .DW     (DW),
            .RD_LAT (RD_LAT)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .addr      (bank_addr[i*AW +: AW]),
            .req       (bank_req[i]),
            .we        (bank_we[i]),
            .din       (bank_din[i*DW +: DW]),
            .accept_en (accept_en),
            .fill_we   (fill_we),
            .fill_addr (fill_cnt),
            .fill_data (fill_val),
            .ack       (bank_ack[i]),
            .dout      (bank_dout[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_vram_banked.sv
// Bench for vram_banked: a RD_LAT=1 and a RD_LAT=2 instance (AW=4, two banks)
// exercised in turn against an array model of bank contents.
module tb_vram_banked;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_s   [2];
    logic [7:0]  addr_s  [2];
    logic [1:0]  req_s   [2];
    logic [1:0]  we_s    [2];
    logic [15:0] din_s   [2];
    logic        fs_s    [2];
    logic [7:0]  fv_s    [2];

    logic [1:0]  ack0, ack1;
    logic [15:0] dout0, dout1;
    logic        busy0, busy1, done0, done1;

    logic [7:0]  mem_m   [2][2][DEPTH];
    logic [7:0]  last_rd [2][2];

    int checks = 0;
    int failures = 0;
    int cur_d = 0;
    int cyc = 0;
    int bcnt [2];
    int dcnt [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy0) bcnt[0]++;
        if (busy1) bcnt[1]++;
        if (done0) dcnt[0]++;
        if (done1) dcnt[1]++;
    end

    vram_banked #(.NUM_BANKS(2), .AW(AW), .DW(DW), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .reset(rst_s[0]), .bank_addr(addr_s[0]), .bank_req(req_s[0]),
        .bank_ack(ack0), .bank_we(we_s[0]), .bank_din(din_s[0]), .bank_dout(dout0),
        .fill_start(fs_s[0]), .fill_value(fv_s[0]), .fill_busy(busy0), .fill_done(done0)
    );

    vram_banked #(.NUM_BANKS(2), .AW(AW), .DW(DW), .RD_LAT(2)) dut_lat2 (
        .clk(clk), .reset(rst_s[1]), .bank_addr(addr_s[1]), .bank_req(req_s[1]),
        .bank_ack(ack1), .bank_we(we_s[1]), .bank_din(din_s[1]), .bank_dout(dout1),
        .fill_start(fs_s[1]), .fill_value(fv_s[1]), .fill_busy(busy1), .fill_done(done1)
    );

    function automatic logic [1:0] ack_of(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction
    function automatic logic [15:0] dout_of(input int d);
        return (d == 0) ? dout0 : dout1;
    endfunction
    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done_of(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic int lat_of(input int d);
        return d + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lat=%0d observed=%h expected=%h", tag, cur_d + 1, obs, exp);
        end
    endtask

    task automatic model_fill(input int d, input logic [7:0] v, input int upto);
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < upto; a++)
                mem_m[d][b][a] = v;
    endtask

    // One client access; called and returns at posedge+1.
    task automatic do_access(input int d, input int b, input bit w,
                             input logic [3:0] a, input logic [7:0] v);
        int n;
        logic [1:0] ak;
        logic [15:0] dv;
        addr_s[d][b*4 +: 4] = a;
        din_s[d][b*8 +: 8]  = v;
        we_s[d][b]          = w;
        req_s[d][b]         = ~req_s[d][b];
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            ak = ack_of(d);
        end while (ak[b] !== req_s[d][b] && n < 20);
        chk("ack_latency", 32'(n), 32'(lat_of(d)));
        dv = dout_of(d);
        if (w) begin
            mem_m[d][b][a] = v;
            chk("dout_held_on_write", {24'b0, dv[b*8 +: 8]}, {24'b0, last_rd[d][b]});
        end else begin
            last_rd[d][b] = mem_m[d][b][a];
            chk("read_data", {24'b0, dv[b*8 +: 8]}, {24'b0, mem_m[d][b][a]});
        end
    endtask

    task automatic verify_all(input int d);
        for (int a = 0; a < DEPTH; a++)
            for (int b = 0; b < 2; b++)
                do_access(d, b, 1'b0, 4'(a), 8'h00);
    endtask

    task automatic run_fill(input int d, input logic [7:0] v);
        int b0, d0;
        fv_s[d] = v;
        fs_s[d] = 1'b1;
        @(posedge clk); #1;
        fs_s[d] = 1'b0;
        b0 = bcnt[d];
        d0 = dcnt[d];
        chk("fill_busy_rise", 32'(busy_of(d)), 32'd1);
        repeat (DEPTH + 3) @(posedge clk);
        #1;
        chk("fill_busy_fall", 32'(busy_of(d)), 32'd0);
        chk("fill_busy_cycles", 32'(bcnt[d] - b0), 32'(DEPTH));
        chk("fill_done_pulses", 32'(dcnt[d] - d0), 32'd1);
        model_fill(d, v, DEPTH);
    endtask

    task automatic run_dut(input int d);
        int n, fs, r_edge, acc_edge, exp_edge, b0, d0;
        logic [1:0] ak;
        logic [15:0] dv;
        logic [3:0] x, y;
        logic [7:0] v1, v2, exp_x;

        cur_d = d;
        rst_s[d] = 1'b1;
        req_s[d] = 2'b00;
        @(posedge clk); #1;
        chk("reset_ack", 32'(ack_of(d)), 32'd0);
        chk("reset_dout", 32'(dout_of(d)), 32'd0);
        chk("reset_busy", 32'(busy_of(d)), 32'd0);
        chk("reset_done", 32'(done_of(d)), 32'd0);
        rst_s[d] = 1'b0;
        last_rd[d][0] = 8'h00;
        last_rd[d][1] = 8'h00;
        @(posedge clk); #1;

        run_fill(d, 8'h00);
        verify_all(d);

        do_access(d, 0, 1'b1, 4'h4, 8'hA5);
        do_access(d, 0, 1'b0, 4'h4, 8'h00);
        do_access(d, 1, 1'b0, 4'h4, 8'h00);

        // Both banks requested on the same edge.
        do_access(d, 0, 1'b1, 4'h9, 8'h3C);
        do_access(d, 1, 1'b1, 4'h9, 8'hC3);
        addr_s[d] = 8'h99;
        we_s[d]   = 2'b00;
        req_s[d]  = ~req_s[d];
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            ak = ack_of(d);
        end while (ak[0] !== req_s[d][0] && n < 20);
        chk("dual_latency", 32'(n), 32'(lat_of(d)));
        chk("dual_ack1_same_edge", 32'(ak[1]), 32'(req_s[d][1]));
        chk("dual_data", 32'(dout_of(d)), 32'h0000_C33C);
        last_rd[d][0] = 8'h3C;
        last_rd[d][1] = 8'hC3;

        for (int i = 0; i < 40; i++)
            do_access(d, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom));

        // Read accepted just before fill_start returns pre-fill data; a read
        // issued mid-fill waits for IDLE and returns the fill value.
        x = 4'($urandom_range(0, 15));
        y = 4'($urandom_range(0, 15));
        v1 = 8'($urandom_range(0, 254));
        exp_x = mem_m[d][1][x];
        addr_s[d][7:4] = x;
        we_s[d][1] = 1'b0;
        req_s[d][1] = ~req_s[d][1];
        @(posedge clk); #1;
        fv_s[d] = v1;
        fs_s[d] = 1'b1;
        @(posedge clk); #1;
        fs = cyc;
        fs_s[d] = 1'b0;
        b0 = bcnt[d];
        d0 = dcnt[d];
        ak = ack_of(d);
        dv = dout_of(d);
        chk("prefill_ack", 32'(ak[1]), 32'(req_s[d][1]));
        chk("prefill_data", 32'(dv[15:8]), 32'(exp_x));
        last_rd[d][1] = exp_x;
        chk("fill2_busy", 32'(busy_of(d)), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        r_edge = cyc;
        addr_s[d][3:0] = y;
        we_s[d][0] = 1'b0;
        req_s[d][0] = ~req_s[d][0];
        acc_edge = (r_edge + 1 < fs) ? r_edge + 1
                 : ((r_edge + 1 > fs + DEPTH + 1) ? r_edge + 1 : fs + DEPTH + 1);
        exp_edge = acc_edge + lat_of(d) - 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            fs_s[d] = (cyc == fs + 7);
            fv_s[d] = (cyc == fs + 7) ? 8'hFF : v1;
            ak = ack_of(d);
        end while (ak[0] !== req_s[d][0] && n < 60);
        fs_s[d] = 1'b0;
        chk("held_ack_edge", 32'(cyc - fs), 32'(exp_edge - fs));
        dv = dout_of(d);
        chk("held_read_data", 32'(dv[7:0]), 32'(v1));
        model_fill(d, v1, DEPTH);
        last_rd[d][0] = v1;
        repeat (3) @(posedge clk);
        #1;
        chk("fill2_busy_cycles", 32'(bcnt[d] - b0), 32'(DEPTH));
        chk("fill2_done_pulses", 32'(dcnt[d] - d0), 32'd1);
        verify_all(d);

        // Reset after five fill writes.
        for (int b = 0; b < 2; b++) begin
            ak = ack_of(d);
            if (ak[b] == 1'b0)
                do_access(d, b, 1'b0, 4'($urandom_range(0, 15)), 8'h00);
        end
        chk("acks_before_reset", 32'(ack_of(d)), 32'(req_s[d]));
        v2 = v1 ^ 8'h5A;
        fv_s[d] = v2;
        fs_s[d] = 1'b1;
        @(posedge clk); #1;
        fs_s[d] = 1'b0;
        b0 = bcnt[d];
        d0 = dcnt[d];
        repeat (5) @(posedge clk);
        #1;
        rst_s[d] = 1'b1;
        req_s[d] = 2'b00;
        #1;
        chk("midfill_reset_busy", 32'(busy_of(d)), 32'd0);
        chk("midfill_reset_ack", 32'(ack_of(d)), 32'd0);
        chk("midfill_reset_dout", 32'(dout_of(d)), 32'd0);
        @(posedge clk); #1;
        rst_s[d] = 1'b0;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        chk("midfill_busy_cycles", 32'(bcnt[d] - b0), 32'd5);
        chk("midfill_no_done", 32'(dcnt[d] - d0), 32'd0);
        model_fill(d, v2, 5);
        last_rd[d][0] = 8'h00;
        last_rd[d][1] = 8'h00;
        verify_all(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d]  = 1'b1;
            addr_s[d] = '0;
            req_s[d]  = '0;
            we_s[d]   = '0;
            din_s[d]  = '0;
            fs_s[d]   = 1'b0;
            fv_s[d]   = '0;
            bcnt[d]   = 0;
            dcnt[d]   = 0;
        end
        for (int d = 0; d < 2; d++)
            run_dut(d);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
